// File: rtl/spi_pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : spi_pwm_pkg                                                |
// | Shared constants for the SPI-controlled PWM register bank: register  |
// | map addresses, the ID magic byte, the command write bit and the      |
// | frame decoder state encoding.                                        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package spi_pwm_pkg;

  // Register map (7-bit word addresses)
  localparam logic [6:0] ADDR_ID      = 7'h00;
  localparam logic [6:0] ADDR_LED     = 7'h01;
  localparam logic [6:0] ADDR_ERR     = 7'h02;
  localparam logic [6:0] ADDR_CH_BASE = 7'h04;

  // Upper byte of the ID register
  localparam logic [7:0] ID_MAGIC = 8'h5A;

  // Bit of the command byte that selects write (1) or read (0)
  localparam int CMD_WR_BIT = 7;

  // Frame decoder states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WR_LO = 3'd2,
    ST_WR_HI = 3'd3,
    ST_RD    = 3'd4
  } frame_state_t;

  // Address of the frequency (sel_duty = 0) or duty (sel_duty = 1) register
  // of channel ch.
  function automatic logic [6:0] ch_addr(input int ch, input logic sel_duty);
    return 7'(int'(ADDR_CH_BASE) + 2 * ch + int'(sel_duty));
  endfunction

endpackage : spi_pwm_pkg
`default_nettype wire

// File: rtl/spi_frame_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_frame_decoder                                          |
// | Turns the byte stream of one ss-low SPI frame into register write    |
// | and read-back strobes: command/address byte followed by a burst of   |
// | 16-bit little-endian words with address auto-increment.              |
// |                                                                      |
// | Ports:                                                               |
// |   clk, rst_n         clock, asynchronous active-low reset            |
// |   ss                 slave select (active low, asynchronous)         |
// |   rx_byte_available  byte-valid level from spi_slave (clk domain)    |
// |   rx_byte            received byte                                   |
// |   wr_en/addr/data    one-cycle write strobe with word and address    |
// |   rd_en/addr/phase   one-cycle read strobe; phase 1 = high byte      |
// |   frame_err          one-cycle pulse: frame ended mid-word           |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module spi_frame_decoder
  import spi_pwm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ss,
  input  logic        rx_byte_available,
  input  logic [7:0]  rx_byte,
  output logic        wr_en,
  output logic [6:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_en,
  output logic [6:0]  rd_addr,
  output logic        rd_phase,
  output logic        frame_err
);

  logic         r_ss_meta;
  logic         r_ss_s;
  logic         r_rx_avail_d;
  frame_state_t r_state;
  logic [6:0]   r_addr;
  logic [7:0]   r_lo;
  logic         r_phase;   // 0: next dummy byte returns high byte

  logic w_byte_evt;
  logic w_evt;

  assign w_byte_evt = rx_byte_available & ~r_rx_avail_d;
  // A frame end in the same cycle as a byte wins: the byte is dropped.
  assign w_evt      = w_byte_evt & ~r_ss_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_meta    <= 1'b1;
      r_ss_s       <= 1'b1;
      r_rx_avail_d <= 1'b0;
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_lo         <= '0;
      r_phase      <= 1'b0;
    end else begin
      r_ss_meta    <= ss;
      r_ss_s       <= r_ss_meta;
      r_rx_avail_d <= rx_byte_available;
      if (r_ss_s) begin
        r_state <= ST_IDLE;
        r_phase <= 1'b0;
        r_lo    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_CMD;
          ST_CMD: begin
            if (w_evt) begin
              r_addr  <= rx_byte[6:0];
              r_phase <= 1'b0;
              r_state <= rx_byte[CMD_WR_BIT] ? ST_WR_LO : ST_RD;
            end
          end
          ST_WR_LO: begin
            if (w_evt) begin
              r_lo    <= rx_byte;
              r_state <= ST_WR_HI;
            end
          end
          ST_WR_HI: begin
            if (w_evt) begin
              r_addr  <= r_addr + 7'd1;
              r_state <= ST_WR_LO;
            end
          end
          ST_RD: begin
            if (w_evt) begin
              r_phase <= ~r_phase;
              if (r_phase) r_addr <= r_addr + 7'd1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Strobes are decoded from registered state and the byte edge so that
  // the parent can commit at the end of the byte-event cycle.
  always_comb begin
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = r_addr;
    rd_phase = 1'b0;
    if (w_evt) begin
      case (r_state)
        ST_CMD: begin
          if (!rx_byte[CMD_WR_BIT]) begin
            rd_en   = 1'b1;
            rd_addr = rx_byte[6:0];
          end
        end
        ST_WR_HI: wr_en = 1'b1;
        ST_RD: begin
          rd_en    = 1'b1;
          rd_phase = ~r_phase;
          rd_addr  = r_phase ? (r_addr + 7'd1) : r_addr;
        end
        default: ;
      endcase
    end
  end

  assign wr_addr   = r_addr;
  assign wr_data   = {rx_byte, r_lo};
  assign frame_err = r_ss_s & (r_state == ST_WR_HI);

endmodule : spi_frame_decoder
`default_nettype wire

// File: rtl/spi_pwm_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_pwm_regfile                                            |
// | SPI register bank for the PWM board: per-channel frequency and duty  |
// | registers, LED bits, ID and a saturating frame-error counter.        |
// |                                                                      |
// | Ports:                                                               |
// |   clk, rst_n         clock, asynchronous active-low reset            |
// |   ss                 slave select (active low, asynchronous)         |
// |   rx_byte_available  byte-valid level from spi_slave                 |
// |   rx_byte            received byte                                   |
// |   tx_byte            next byte for spi_slave to shift out            |
// |   led                LED control bits, active high                   |
// |   pwm_freq           channel k frequency at [16k+15:16k]             |
// |   pwm_duty           channel k duty (usec) at [16k+15:16k]           |
// |   cfg_update         one-cycle pulse on any channel register commit  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module spi_pwm_regfile
  import spi_pwm_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int NUM_LED  = 4,
  parameter int DEF_FREQ = 490,
  parameter int DEF_DUTY = 1250
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ss,
  input  logic                  rx_byte_available,
  input  logic [7:0]            rx_byte,
  output logic [7:0]            tx_byte,
  output logic [NUM_LED-1:0]    led,
  output logic [16*NUM_CH-1:0]  pwm_freq,
  output logic [16*NUM_CH-1:0]  pwm_duty,
  output logic                  cfg_update
);

  logic        w_wr_en;
  logic [6:0]  w_wr_addr;
  logic [15:0] w_wr_data;
  logic        w_rd_en;
  logic [6:0]  w_rd_addr;
  logic        w_rd_phase;
  logic        w_frame_err;
  logic [15:0] w_rd_word;
  logic [NUM_CH-1:0] w_ch_wr;
  logic        w_err_wr;

  logic [7:0]  r_err_cnt;

  spi_frame_decoder u_decoder (
    .clk               (clk),
    .rst_n             (rst_n),
    .ss                (ss),
    .rx_byte_available (rx_byte_available),
    .rx_byte           (rx_byte),
    .wr_en             (w_wr_en),
    .wr_addr           (w_wr_addr),
    .wr_data           (w_wr_data),
    .rd_en             (w_rd_en),
    .rd_addr           (w_rd_addr),
    .rd_phase          (w_rd_phase),
    .frame_err         (w_frame_err)
  );

  // Channel registers
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [6:0] FREQ_ADDR = ch_addr(k, 1'b0);
    localparam logic [6:0] DUTY_ADDR = ch_addr(k, 1'b1);

    logic [15:0] r_freq;
    logic [15:0] r_duty;
    logic        w_hit_freq;
    logic        w_hit_duty;

    assign w_hit_freq = w_wr_en & (w_wr_addr == FREQ_ADDR);
    assign w_hit_duty = w_wr_en & (w_wr_addr == DUTY_ADDR);
    assign w_ch_wr[k] = w_hit_freq | w_hit_duty;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_freq <= 16'(DEF_FREQ);
        r_duty <= 16'(DEF_DUTY);
      end else begin
        if (w_hit_freq) r_freq <= w_wr_data;
        if (w_hit_duty) r_duty <= w_wr_data;
      end
    end

    assign pwm_freq[16*k +: 16] = r_freq;
    assign pwm_duty[16*k +: 16] = r_duty;
  end

  assign w_err_wr = w_wr_en & (w_wr_addr == ADDR_ERR);

  // LED, error counter, tx byte and update pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led        <= '0;
      r_err_cnt  <= '0;
      tx_byte    <= '0;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= |w_ch_wr;
      if (w_wr_en && (w_wr_addr == ADDR_LED)) led <= w_wr_data[NUM_LED-1:0];
      // Clear takes effect first, so a coincident error leaves a count of 1.
      if (w_err_wr) begin
        r_err_cnt <= w_frame_err ? 8'd1 : 8'd0;
      end else if (w_frame_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (w_rd_en) tx_byte <= w_rd_phase ? w_rd_word[15:8] : w_rd_word[7:0];
    end
  end

  // Read mux; sampled only when tx_byte loads, so it always reflects
  // registers committed in earlier cycles.
  always_comb begin
    w_rd_word = 16'h0000;
    case (w_rd_addr)
      ADDR_ID:  w_rd_word = {ID_MAGIC, 8'(NUM_CH)};
      ADDR_LED: w_rd_word = 16'(led);
      ADDR_ERR: w_rd_word = {8'h00, r_err_cnt};
      default:  ;
    endcase
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_rd_addr == ch_addr(k, 1'b0)) w_rd_word = pwm_freq[16*k +: 16];
      if (w_rd_addr == ch_addr(k, 1'b1)) w_rd_word = pwm_duty[16*k +: 16];
    end
  end

endmodule : spi_pwm_regfile
`default_nettype wire
